// File: rtl/trg_one_gen.sv
// Switch/button conditioner: 2-flop synchroniser, prescaled debounce FSM,
// and a registered one-clock trigger on the selected edge(s) of the debounced level.
module trg_one_gen #(
  parameter logic [15:0] PRESCALE = 16'd1000,
  parameter logic [3:0]  STABLE   = 4'd8,
  parameter logic [1:0]  EDGE     = 2'b01
) (
  input  logic CLK,
  input  logic RN,
  input  logic SW,
  input  logic EN,
  output logic TRG_ONE,
  output logic LEVEL
);

  // Zero settings behave as one.
  localparam logic [15:0] PMAX = (PRESCALE == 16'd0) ? 16'd0 : PRESCALE - 16'd1;
  localparam logic [3:0]  ST   = (STABLE == 4'd0) ? 4'd1 : STABLE;

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic [15:0] pcnt;
  logic [3:0]  scnt;
  logic [3:0]  scnt_inc;
  logic        tick;

  assign tick     = (pcnt == PMAX);
  assign scnt_inc = scnt + 4'd1;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN)
      pcnt <= '0;
    else if (tick)
      pcnt <= '0;
    else
      pcnt <= pcnt + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state   <= LOW;
      scnt    <= '0;
      LEVEL   <= 1'b0;
      TRG_ONE <= 1'b0;
    end else begin
      TRG_ONE <= 1'b0;
      if (tick) begin
        unique case (state)
          LOW: begin
            if (sync2) begin
              if (ST <= 4'd1) begin
                state   <= HIGH;
                LEVEL   <= 1'b1;
                TRG_ONE <= EN & EDGE[0];
              end else begin
                state <= RISE_WAIT;
                scnt  <= 4'd1;
              end
            end
          end
          RISE_WAIT: begin
            if (sync2) begin
              if (scnt_inc == ST) begin
                state   <= HIGH;
                scnt    <= '0;
                LEVEL   <= 1'b1;
                TRG_ONE <= EN & EDGE[0];
              end else begin
                scnt <= scnt_inc;
              end
            end else begin
              state <= LOW;
              scnt  <= '0;
            end
          end
          HIGH: begin
            if (!sync2) begin
              if (ST <= 4'd1) begin
                state   <= LOW;
                LEVEL   <= 1'b0;
                TRG_ONE <= EN & EDGE[1];
              end else begin
                state <= FALL_WAIT;
                scnt  <= 4'd1;
              end
            end
          end
          FALL_WAIT: begin
            if (!sync2) begin
              if (scnt_inc == ST) begin
                state   <= LOW;
                scnt    <= '0;
                LEVEL   <= 1'b0;
                TRG_ONE <= EN & EDGE[1];
              end else begin
                scnt <= scnt_inc;
              end
            end else begin
              state <= HIGH;
              scnt  <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trg_one_gen.sv
// Bench for trg_one_gen: five parameterisations share one stimulus stream,
// checked against a behavioural model through a scoreboard queue plus a hand-written vector table.
module tb_trg_one_gen;

  localparam int N = 5;

  logic       CLK;
  logic       RN;
  logic       SW;
  logic       EN;
  logic [N-1:0] trg;
  logic [N-1:0] lvl;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  trg_one_gen #(.PRESCALE(16'd1), .STABLE(4'd4), .EDGE(2'b01)) dut0 (
    .CLK(CLK), .RN(RN), .SW(SW), .EN(EN), .TRG_ONE(trg[0]), .LEVEL(lvl[0]));
  trg_one_gen #(.PRESCALE(16'd1), .STABLE(4'd4), .EDGE(2'b11)) dut1 (
    .CLK(CLK), .RN(RN), .SW(SW), .EN(EN), .TRG_ONE(trg[1]), .LEVEL(lvl[1]));
  trg_one_gen #(.PRESCALE(16'd1), .STABLE(4'd4), .EDGE(2'b00)) dut2 (
    .CLK(CLK), .RN(RN), .SW(SW), .EN(EN), .TRG_ONE(trg[2]), .LEVEL(lvl[2]));
  trg_one_gen #(.PRESCALE(16'd3), .STABLE(4'd2), .EDGE(2'b10)) dut3 (
    .CLK(CLK), .RN(RN), .SW(SW), .EN(EN), .TRG_ONE(trg[3]), .LEVEL(lvl[3]));
  trg_one_gen #(.PRESCALE(16'd0), .STABLE(4'd0), .EDGE(2'b11)) dut4 (
    .CLK(CLK), .RN(RN), .SW(SW), .EN(EN), .TRG_ONE(trg[4]), .LEVEL(lvl[4]));

  // Model: level flips once STABLE consecutive ticks have sampled the opposite value.
  int unsigned m_ps [N] = '{1, 1, 1, 3, 1};
  int unsigned m_st [N] = '{4, 4, 4, 2, 1};
  logic [1:0]  m_edge [N] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
  logic        m_s1 [N];
  logic        m_s2 [N];
  logic        m_lvl [N];
  logic        m_trg [N];
  int unsigned m_pc [N];
  int unsigned m_run [N];

  typedef struct {
    logic [N-1:0] trg;
    logic [N-1:0] lvl;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic rn;
    logic sw;
    logic en;
    logic trg;
    logic lvl;
  } vec_t;

  task automatic model_step(input logic rn, input logic sw, input logic en);
    bit tick;
    for (int i = 0; i < N; i++) begin
      if (!rn) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0; m_trg[i] = 1'b0;
        m_pc[i] = 0; m_run[i] = 0;
      end else begin
        tick = (m_pc[i] == m_ps[i] - 1);
        m_pc[i] = tick ? 0 : m_pc[i] + 1;
        m_trg[i] = 1'b0;
        if (tick) begin
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] >= m_st[i]) begin
              m_lvl[i] = m_s2[i];
              m_run[i] = 0;
              m_trg[i] = en && (m_s2[i] ? m_edge[i][0] : m_edge[i][1]);
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = sw;
      end
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic sw, input logic en,
                      output logic [N-1:0] t_out, output logic [N-1:0] l_out);
    exp_t e;
    RN = rn; SW = sw; EN = en;
    model_step(rn, sw, en);
    for (int i = 0; i < N; i++) begin
      e.trg[i] = m_trg[i];
      e.lvl[i] = m_lvl[i];
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (trg[i] !== e.trg[i]) begin
        miscompares++;
        $display("FAIL %s dut%0d TRG_ONE got %b want %b at %0t", tag, i, trg[i], e.trg[i], $time);
      end
      vectors++;
      if (lvl[i] !== e.lvl[i]) begin
        miscompares++;
        $display("FAIL %s dut%0d LEVEL got %b want %b at %0t", tag, i, lvl[i], e.lvl[i], $time);
      end
    end
    t_out = trg;
    l_out = lvl;
  endtask

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    vec_t tbl[32];
    logic [N-1:0] t;
    logic [N-1:0] l;
    int cnt[N];
    int first;
    logic sw_r;
    logic en_r;
    logic rn_r;

    RN = 1'b0; SW = 1'b1; EN = 1'b1;

    // Reset with SW high, release, clean rise, clean fall, bounce then steady high (dut0 view).
    for (int i = 0; i < 32; i++) begin
      tbl[i].rn  = (i >= 3);
      tbl[i].sw  = !((i >= 12 && i <= 19) || i == 23);
      tbl[i].en  = 1'b1;
      tbl[i].trg = (i == 8 || i == 29);
      tbl[i].lvl = (i >= 8 && i <= 16) || (i >= 29);
    end

    for (int i = 0; i < 32; i++) begin
      step("table", tbl[i].rn, tbl[i].sw, tbl[i].en, t, l);
      check($sformatf("table[%0d] trg", i), int'(t[0]), int'(tbl[i].trg));
      check($sformatf("table[%0d] lvl", i), int'(l[0]), int'(tbl[i].lvl));
    end

    // Enable: settle low, rise with EN=0, then raise EN with nothing pending.
    for (int i = 0; i < 10; i++) step("settle_low", 1'b1, 1'b0, 1'b1, t, l);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int i = 0; i < 12; i++) begin
      step("en_off_rise", 1'b1, 1'b1, 1'b0, t, l);
      for (int k = 0; k < N; k++) cnt[k] += int'(t[k]);
    end
    check("en_off level", int'(l[0]), 1);
    check("en_off pulses dut0", cnt[0], 0);
    check("en_off pulses dut1", cnt[1], 0);
    for (int i = 0; i < 6; i++) begin
      step("en_back_on", 1'b1, 1'b1, 1'b1, t, l);
      for (int k = 0; k < N; k++) cnt[k] += int'(t[k]);
    end
    check("en_on no late pulse", cnt[0] + cnt[1] + cnt[4], 0);

    // Edge select over a full 0->1->0 cycle.
    for (int i = 0; i < 10; i++) step("settle_low2", 1'b1, 1'b0, 1'b1, t, l);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int i = 0; i < 10; i++) begin
      step("edge_rise", 1'b1, 1'b1, 1'b1, t, l);
      for (int k = 0; k < N; k++) cnt[k] += int'(t[k]);
    end
    check("edge00 level high", int'(l[2]), 1);
    for (int i = 0; i < 10; i++) begin
      step("edge_fall", 1'b1, 1'b0, 1'b1, t, l);
      for (int k = 0; k < N; k++) cnt[k] += int'(t[k]);
    end
    check("edge00 level low", int'(l[2]), 0);
    check("edge01 pulses", cnt[0], 1);
    check("edge11 pulses", cnt[1], 2);
    check("edge00 pulses", cnt[2], 0);
    check("edge10 pulses", cnt[3], 1);

    // Reset mid-debounce: dut0 reaches scnt=3 after five SW-high edges.
    for (int i = 0; i < 5; i++) step("pre_abort", 1'b1, 1'b1, 1'b1, t, l);
    check("pre_abort level", int'(l[0]), 0);
    for (int i = 0; i < 2; i++) begin
      step("abort_reset", 1'b0, 1'b1, 1'b1, t, l);
      check("abort_reset trg", int'(t[0]), 0);
      check("abort_reset lvl", int'(l[0]), 0);
    end
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step("post_abort", 1'b1, 1'b1, 1'b1, t, l);
      if (t[0] && first == 0) first = i;
    end
    check("post_abort pulse step", first, 6);

    // Random soak, scoreboard only.
    sw_r = 1'b0; en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) sw_r = ~sw_r;
      if ($urandom_range(0, 40) == 0) en_r = ~en_r;
      rn_r = ($urandom_range(0, 199) != 0);
      step("random", rn_r, sw_r, en_r, t, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
